hs32_exec_seq: RTL

//  Execute sequencer for the hs32 ALU and its single-port register file.

---
 rtl/hs32_exec_seq.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/hs32_exec_seq.sv
// hs32 execute sequencer: reads Rm then Rn/imm, drives the ALU, writes the result back to Rd.
// Optional NZCV flag register is enabled by defining HS32_EXEC_FLAGS_EN.
module hs32_exec_seq #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_aluop,
    input  logic [AW-1:0] req_rd,
    input  logic [AW-1:0] req_rm,
    input  logic [AW-1:0] req_rn,
    input  logic          req_use_imm,
    input  logic [DW-1:0] req_imm,
    output logic          rf_en_n,
    output logic          rf_rw,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_wdata,
    input  logic [DW-1:0] rf_rdata,
    output logic [2:0]    alu_op,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_res,
    input  logic          alu_c,
    input  logic          alu_v,
    output logic          done_valid,
    output logic [AW-1:0] done_rd,
    output logic [DW-1:0] done_res,
    output logic          busy
`ifdef HS32_EXEC_FLAGS_EN
    ,
    output logic [3:0]    flags
`endif
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        EXEC = 3'd3,
        WB   = 3'd4
    } state_t;

    state_t        state_q;

    // Request fields latched on accept; rm is consumed immediately as the first read address.
    logic [2:0]    op_q;
    logic [AW-1:0] rd_q;
    logic [AW-1:0] rn_q;
    logic          use_imm_q;
    logic [DW-1:0] imm_q;

    logic          rf_en_n_q;
    logic          rf_rw_q;
    logic [AW-1:0] rf_addr_q;
    logic [DW-1:0] rf_wdata_q;

    logic [2:0]    alu_op_q;
    logic [DW-1:0] alu_a_q;
    logic [DW-1:0] alu_b_q;

    logic          done_valid_q;
    logic [AW-1:0] done_rd_q;
    logic [DW-1:0] done_res_q;

`ifdef HS32_EXEC_FLAGS_EN
    logic [3:0]    flags_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            op_q         <= '0;
            rd_q         <= '0;
            rn_q         <= '0;
            use_imm_q    <= 1'b0;
            imm_q        <= '0;
            rf_en_n_q    <= 1'b1;
            rf_rw_q      <= 1'b0;
            rf_addr_q    <= '0;
            rf_wdata_q   <= '0;
            alu_op_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            done_valid_q <= 1'b0;
            done_rd_q    <= '0;
            done_res_q   <= '0;
`ifdef HS32_EXEC_FLAGS_EN
            flags_q      <= 4'b0000;
`endif
        end else begin
            done_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_q      <= req_aluop;
                        rd_q      <= req_rd;
                        rn_q      <= req_rn;
                        use_imm_q <= req_use_imm;
                        imm_q     <= req_imm;
                        rf_en_n_q <= 1'b0;
                        rf_rw_q   <= 1'b0;
                        rf_addr_q <= req_rm;
                        state_q   <= RD_A;
                    end
                end
                RD_A: begin
                    // Immediate form skips the second read entirely.
                    rf_en_n_q <= use_imm_q;
                    rf_rw_q   <= 1'b0;
                    rf_addr_q <= rn_q;
                    state_q   <= RD_B;
                end
                RD_B: begin
                    rf_en_n_q <= 1'b1;
                    alu_op_q  <= op_q;
                    alu_a_q   <= rf_rdata;
                    if (use_imm_q) begin
                        alu_b_q <= imm_q;
                    end
                    state_q   <= EXEC;
                end
                EXEC: begin
                    if (!use_imm_q) begin
                        alu_b_q <= rf_rdata;
                    end
                    rf_en_n_q    <= 1'b0;
                    rf_rw_q      <= 1'b1;
                    rf_addr_q    <= rd_q;
                    rf_wdata_q   <= alu_res;
                    done_valid_q <= 1'b1;
                    done_rd_q    <= rd_q;
                    done_res_q   <= alu_res;
`ifdef HS32_EXEC_FLAGS_EN
                    flags_q      <= {alu_res[DW-1], (alu_res == '0), alu_c, alu_v};
`endif
                    state_q      <= WB;
                end
                WB: begin
                    rf_en_n_q <= 1'b1;
                    rf_rw_q   <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    rf_en_n_q <= 1'b1;
                    rf_rw_q   <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    // Operand B of a reg-reg op arrives from the regfile during EXEC itself; it is
    // captured at the end of EXEC so the ALU input stays stable until the next op.
    assign alu_b = (state_q == EXEC && !use_imm_q) ? rf_rdata : alu_b_q;

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign rf_en_n    = rf_en_n_q;
    assign rf_rw      = rf_rw_q;
    assign rf_addr    = rf_addr_q;
    assign rf_wdata   = rf_wdata_q;
    assign alu_op     = alu_op_q;
    assign alu_a      = alu_a_q;
    assign done_valid = done_valid_q;
    assign done_rd    = done_rd_q;
    assign done_res   = done_res_q;

`ifdef HS32_EXEC_FLAGS_EN
    assign flags = flags_q;
`else
    logic unused_alu_flags;
    assign unused_alu_flags = alu_c ^ alu_v;
`endif

endmodule
